// File: rtl/i2c_slave_rx_frontend.sv
// I2C target receive front end.
// Oversamples SCL/SDA on pclk, detects START/STOP, shifts in the address,
// register-address and data bytes, drives ACK/NACK, and emits a byte stream
// with sideband flags for the downstream transaction collector.
// Optional feature: define I2C_GENERAL_CALL_EN to also ACK the general-call
// address 7'h00 with W and treat the transfer as a write.
module i2c_slave_rx_frontend #(
    parameter int                             SLAVE_ADDRESS_WIDTH = 7,
    parameter int                             DATA_WIDTH          = 8,
    parameter int                             MAXIMUM_BYTES       = 128,
    parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE_ADDRESS       = 7'h68,
    parameter int                             SYNC_STAGES         = 2
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  addr_match,
    output logic                  read_write,
    output logic [DATA_WIDTH-1:0] byte_data,
    output logic                  byte_valid,
    output logic                  byte_is_reg,
    output logic [7:0]            byte_count,
    output logic                  overflow
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [7:0]           MAX_COUNT = 8'(MAXIMUM_BYTES);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] REG      = 3'd3;
    localparam logic [2:0] REG_ACK  = 3'd4;
    localparam logic [2:0] DATA     = 3'd5;
    localparam logic [2:0] DATA_ACK = 3'd6;
    localparam logic [2:0] IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_cond;
    logic                   stop_cond;

    logic [2:0]             state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_WIDTH-2:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  rx_byte;
    logic                   receiving;
    logic                   byte_done;
    logic                   addr_hit;

    // Synchronize the async bus pins; preset to 1 so reset looks like an idle bus
    always_ff @(posedge pclk) begin
        if (!areset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev;
    assign scl_fall   = ~scl_s & scl_prev;
    assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign rx_byte    = {shift_reg, sda_s};
    assign receiving  = (state == ADDR) || (state == REG) || (state == DATA);
    assign byte_done  = receiving && scl_rise && (bit_cnt == BIT_LAST);

`ifdef I2C_GENERAL_CALL_EN
    assign addr_hit = (rx_byte[SLAVE_ADDRESS_WIDTH:1] == SLAVE_ADDRESS) ||
                      ((rx_byte[SLAVE_ADDRESS_WIDTH:1] == '0) && !rx_byte[0]);
`else
    assign addr_hit = (rx_byte[SLAVE_ADDRESS_WIDTH:1] == SLAVE_ADDRESS);
`endif

    // Protocol FSM: bus conditions first (START wins over STOP), then per-state byte handling
    always_ff @(posedge pclk) begin
        if (!areset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            sda_oe      <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            addr_match  <= 1'b0;
            read_write  <= 1'b0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            byte_is_reg <= 1'b0;
            byte_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            byte_valid  <= 1'b0;
            byte_is_reg <= 1'b0;
            if (start_cond) begin
                start_det  <= 1'b1;
                state      <= ADDR;
                bit_cnt    <= '0;
                byte_count <= '0;
                overflow   <= 1'b0;
                addr_match <= 1'b0;
                read_write <= 1'b0;
                sda_oe     <= 1'b0;
            end else if (stop_cond) begin
                stop_det   <= 1'b1;
                state      <= IDLE;
                bit_cnt    <= '0;
                addr_match <= 1'b0;
                sda_oe     <= 1'b0;
            end else begin
                if (receiving && scl_rise) begin
                    shift_reg <= rx_byte[DATA_WIDTH-2:0];
                    bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                end
                case (state)
                    ADDR: begin
                        if (byte_done) begin
                            if (addr_hit) begin
                                state      <= ADDR_ACK;
                                addr_match <= 1'b1;
                                read_write <= rx_byte[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    REG: begin
                        if (byte_done) begin
                            byte_data   <= rx_byte;
                            byte_valid  <= 1'b1;
                            byte_is_reg <= 1'b1;
                            state       <= REG_ACK;
                        end
                    end
                    DATA: begin
                        if (byte_done) begin
                            if (byte_count < MAX_COUNT) begin
                                byte_data  <= rx_byte;
                                byte_valid <= 1'b1;
                                byte_count <= byte_count + 8'd1;
                                state      <= DATA_ACK;
                            end else begin
                                overflow <= 1'b1;
                                state    <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                if (state == ADDR_ACK) begin
                                    state <= read_write ? IGNORE : REG;
                                end else begin
                                    state <= DATA;
                                end
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx_frontend.sv
// Directed testbench for i2c_slave_rx_frontend.
// A bus-master model drives SCL/SDA (open drain, wired with the DUT's sda_oe);
// expected bytes are queued when driven and compared when byte_valid fires.
module tb_i2c_slave_rx_frontend;

    logic       pclk = 1'b0;
    logic       areset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       start_det;
    logic       stop_det;
    logic       addr_match;
    logic       read_write;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_is_reg;
    logic [7:0] byte_count;
    logic       overflow;

    int compared = 0;
    int mismatched = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int oe_rise_cnt = 0;
    logic oe_d = 1'b0;
    logic [8:0] exp_q[$];

`ifdef I2C_GENERAL_CALL_EN
    localparam logic GC_ACK = 1'b1;
`else
    localparam logic GC_ACK = 1'b0;
`endif

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_rx_frontend dut (
        .pclk        (pclk),
        .areset      (areset),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_oe      (sda_oe),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .addr_match  (addr_match),
        .read_write  (read_write),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_is_reg (byte_is_reg),
        .byte_count  (byte_count),
        .overflow    (overflow)
    );

    // 100 MHz system clock
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_cycles(5);
        scl_m = 1'b1;
        wait_cycles(10);
        sda_m = 1'b0;
        wait_cycles(10);
        scl_m = 1'b0;
        wait_cycles(2);
    endtask

    task automatic bus_stop();
        scl_m = 1'b0;
        wait_cycles(4);
        sda_m = 1'b0;
        wait_cycles(6);
        scl_m = 1'b1;
        wait_cycles(10);
        sda_m = 1'b1;
        wait_cycles(10);
    endtask

    // Sends nbits of b MSB first; a full byte also clocks the ACK bit and returns it
    task automatic applyStimulus(input logic [7:0] b, input int nbits, output logic ack);
        ack = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            wait_cycles(4);
            sda_m = b[7-i];
            wait_cycles(6);
            scl_m = 1'b1;
            wait_cycles(10);
            scl_m = 1'b0;
        end
        if (nbits == 8) begin
            wait_cycles(4);
            sda_m = 1'b1;
            wait_cycles(6);
            scl_m = 1'b1;
            wait_cycles(5);
            ack = ~sda_bus;
            wait_cycles(5);
            scl_m = 1'b0;
        end
    endtask

    // Pulse counters and byte-stream scoreboard
    always @(negedge pclk) begin
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
        if (sda_oe && !oe_d) oe_rise_cnt++;
        oe_d = sda_oe;
        if (byte_valid) begin
            logic [8:0] exp_b;
            checkOutput("byte_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                checkOutput("byte_stream", {23'b0, byte_is_reg, byte_data}, {23'b0, exp_b});
            end
        end
    end

    // Directed test sequence
    initial begin
        logic ack;
        int   s0;
        int   p0;
        int   o0;
        int   ack_cnt;

        $display("[TB] reset");
        wait_cycles(3);
        checkOutput("reset_outputs",
                    {18'b0, sda_oe, start_det, stop_det, addr_match, read_write, byte_valid,
                     byte_is_reg, overflow, byte_data}, 32'd0);
        checkOutput("reset_count", {24'b0, byte_count}, 32'd0);
        areset = 1'b1;
        wait_cycles(5);

        $display("[TB] test 1: basic write");
        s0 = start_cnt;
        p0 = stop_cnt;
        bus_start();
        checkOutput("t1_start_det", start_cnt - s0, 1);
        applyStimulus(8'hD0, 8, ack);
        checkOutput("t1_addr_ack", ack, 1);
        checkOutput("t1_addr_match", addr_match, 1);
        checkOutput("t1_read_write", read_write, 0);
        exp_q.push_back({1'b1, 8'h10});
        applyStimulus(8'h10, 8, ack);
        checkOutput("t1_reg_ack", ack, 1);
        exp_q.push_back({1'b0, 8'hA5});
        applyStimulus(8'hA5, 8, ack);
        checkOutput("t1_data0_ack", ack, 1);
        exp_q.push_back({1'b0, 8'h3C});
        applyStimulus(8'h3C, 8, ack);
        checkOutput("t1_data1_ack", ack, 1);
        bus_stop();
        checkOutput("t1_byte_count", byte_count, 2);
        checkOutput("t1_stop_det", stop_cnt - p0, 1);
        checkOutput("t1_addr_match_clr", addr_match, 0);
        checkOutput("t1_sda_oe", sda_oe, 0);

        $display("[TB] test 2: foreign address");
        o0 = oe_rise_cnt;
        bus_start();
        applyStimulus(8'hAA, 8, ack);
        checkOutput("t2_addr_nack", ack, 0);
        applyStimulus(8'h77, 8, ack);
        checkOutput("t2_data_nack", ack, 0);
        checkOutput("t2_addr_match", addr_match, 0);
        checkOutput("t2_no_oe", oe_rise_cnt - o0, 0);
        bus_stop();

        $display("[TB] test 3: overflow");
        bus_start();
        applyStimulus(8'hD0, 8, ack);
        checkOutput("t3_addr_ack", ack, 1);
        exp_q.push_back({1'b1, 8'h00});
        applyStimulus(8'h00, 8, ack);
        checkOutput("t3_reg_ack", ack, 1);
        ack_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back({1'b0, 8'(i * 3 + 1)});
            applyStimulus(8'(i * 3 + 1), 8, ack);
            if (ack) ack_cnt++;
        end
        checkOutput("t3_ack_count", ack_cnt, 128);
        checkOutput("t3_no_overflow_yet", overflow, 0);
        applyStimulus(8'hEE, 8, ack);
        checkOutput("t3_byte129_nack", ack, 0);
        checkOutput("t3_overflow", overflow, 1);
        checkOutput("t3_byte_count", byte_count, 128);
        bus_stop();

        $display("[TB] test 4: repeated start to read");
        bus_start();
        applyStimulus(8'hD0, 8, ack);
        checkOutput("t4_addr_ack", ack, 1);
        checkOutput("t4_overflow_clr", overflow, 0);
        exp_q.push_back({1'b1, 8'h20});
        applyStimulus(8'h20, 8, ack);
        exp_q.push_back({1'b0, 8'h99});
        applyStimulus(8'h99, 8, ack);
        checkOutput("t4_count_before", byte_count, 1);
        s0 = start_cnt;
        bus_start();
        checkOutput("t4_second_start", start_cnt - s0, 1);
        checkOutput("t4_count_cleared", byte_count, 0);
        applyStimulus(8'hD1, 8, ack);
        checkOutput("t4_read_addr_ack", ack, 1);
        checkOutput("t4_read_write", read_write, 1);
        checkOutput("t4_addr_match", addr_match, 1);
        applyStimulus(8'hFF, 8, ack);
        checkOutput("t4_read_no_ack", ack, 0);
        bus_stop();

        $display("[TB] test 5: stop mid byte");
        p0 = stop_cnt;
        bus_start();
        applyStimulus(8'hD0, 8, ack);
        exp_q.push_back({1'b1, 8'h30});
        applyStimulus(8'h30, 8, ack);
        applyStimulus(8'hC3, 4, ack);
        bus_stop();
        checkOutput("t5_stop_det", stop_cnt - p0, 1);
        checkOutput("t5_sda_oe", sda_oe, 0);
        checkOutput("t5_addr_match", addr_match, 0);
        checkOutput("t5_byte_count", byte_count, 0);

        $display("[TB] test 6: reset mid byte");
        bus_start();
        applyStimulus(8'hD0, 8, ack);
        exp_q.push_back({1'b1, 8'h40});
        applyStimulus(8'h40, 8, ack);
        exp_q.push_back({1'b0, 8'h11});
        applyStimulus(8'h11, 8, ack);
        applyStimulus(8'h5A, 3, ack);
        checkOutput("t6_pre_match", addr_match, 1);
        areset = 1'b0;
        wait_cycles(1);
        areset = 1'b1;
        checkOutput("t6_reset_outputs",
                    {18'b0, sda_oe, start_det, stop_det, addr_match, read_write, byte_valid,
                     byte_is_reg, overflow, byte_data}, 32'd0);
        checkOutput("t6_reset_count", {24'b0, byte_count}, 32'd0);
        bus_stop();
        bus_start();
        applyStimulus(8'hD0, 8, ack);
        checkOutput("t6_addr_ack", ack, 1);
        exp_q.push_back({1'b1, 8'h10});
        applyStimulus(8'h10, 8, ack);
        exp_q.push_back({1'b0, 8'hA5});
        applyStimulus(8'hA5, 8, ack);
        exp_q.push_back({1'b0, 8'h3C});
        applyStimulus(8'h3C, 8, ack);
        checkOutput("t6_data_ack", ack, 1);
        bus_stop();
        checkOutput("t6_byte_count", byte_count, 2);

        $display("[TB] test 7: general call");
        bus_start();
        applyStimulus(8'h00, 8, ack);
        checkOutput("t7_gc_ack", ack, 32'(GC_ACK));
        checkOutput("t7_gc_match", addr_match, 32'(GC_ACK));
        bus_stop();

        wait_cycles(5);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
